// File: rtl/obu_dispatch_ctrl.sv
// obu_dispatch_ctrl: walks the 32-bit bitstream FIFO one OBU at a time.
// It decodes the header, the optional extension byte and the LEB128 size.
// The payload then goes to a sub-parser through a start/done handshake, or the
// controller skips it in-line at up to 4 bytes per cycle.
module obu_dispatch_ctrl #(
    parameter int PARSER_DATA_WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [PARSER_DATA_WIDTH-1:0] data,
    input  logic                         avail,
    input  logic                         start,
    input  logic                         sub_done,
    input  logic [31:0]                  sub_bytes_used,
    input  logic                         sub_pop,
    output logic                         pop,
    output logic [1:0]                   sel,
    output logic                         seq_start,
    output logic                         frame_start,
    output logic                         tile_start,
    output logic [3:0]                   obu_type,
    output logic [31:0]                  obu_size,
    output logic [1:0]                   payload_offset,
    output logic [2:0]                   temporal_id,
    output logic [1:0]                   spatial_id,
    output logic [15:0]                  obu_count,
    output logic                         err,
    output logic [2:0]                   err_code
);

    typedef enum logic [2:0] {S_IDLE, S_HDR, S_EXT, S_LEB, S_DISP, S_SKIP, S_ERR} state_t;

    state_t      state_q, state_n;
    logic [1:0]  ptr_q, ptr_n;
    logic [31:0] remaining_q, rem_n;
    logic [3:0]  leb_idx_q, leb_idx_n;
    logic        first_q, first_n;
    logic [1:0]  sel_n, off_n, sid_n;
    logic [3:0]  type_n;
    logic [31:0] size_n;
    logic [2:0]  tid_n, code_n;
    logic [15:0] cnt_n;
    logic        err_n;

    logic [7:0]  cur_byte;
    logic [5:0]  leb_sh;
    logic [63:0] leb_term;
    logic [31:0] size_acc;
    logic        leb_bad;
    logic [2:0]  room, skip_n, skip_end;
    logic [31:0] done_end, done_rem;

    // Select the byte lane the pointer currently addresses (lane 0 = [31:24]).
    always_comb begin
        case (ptr_q)
            2'd0:    cur_byte = data[31:24];
            2'd1:    cur_byte = data[23:16];
            2'd2:    cur_byte = data[15:8];
            default: cur_byte = data[7:0];
        endcase
    end

    // LEB128 group placement; anything landing at bit 31 or above is an overflow.
    assign leb_sh   = {2'b00, leb_idx_q} * 6'd7;
    assign leb_term = {57'd0, cur_byte[6:0]} << leb_sh;
    assign size_acc = obu_size | leb_term[31:0];
    assign leb_bad  = (leb_idx_q == 4'd8) || (leb_term[63:31] != 33'd0);

    // Skip step: bytes left in the current word, capped by what remains.
    assign room     = 3'd4 - {1'b0, ptr_q};
    assign skip_n   = (remaining_q < {29'd0, room}) ? remaining_q[2:0] : room;
    assign skip_end = {1'b0, ptr_q} + skip_n;

    // Stream position and leftover payload after the sub-parser returns.
    assign done_end = {30'd0, payload_offset} + sub_bytes_used;
    assign done_rem = obu_size - sub_bytes_used;

    // Next-state, next-register and pop/start outputs.
    always_comb begin
        state_n     = state_q;
        ptr_n       = ptr_q;
        rem_n       = remaining_q;
        leb_idx_n   = leb_idx_q;
        first_n     = 1'b0;
        sel_n       = sel;
        type_n      = obu_type;
        size_n      = obu_size;
        off_n       = payload_offset;
        tid_n       = temporal_id;
        sid_n       = spatial_id;
        cnt_n       = obu_count;
        err_n       = err;
        code_n      = err_code;
        pop         = 1'b0;
        seq_start   = 1'b0;
        frame_start = 1'b0;
        tile_start  = 1'b0;
        case (state_q)
            S_IDLE: if (start) state_n = S_HDR;
            S_HDR: if (avail) begin
                ptr_n = ptr_q + 2'd1;
                pop   = (ptr_q == 2'd3);
                if (cur_byte[7]) begin
                    state_n = S_ERR; err_n = 1'b1; code_n = 3'd1;
                end else if (!cur_byte[1]) begin
                    state_n = S_ERR; err_n = 1'b1; code_n = 3'd2;
                end else begin
                    type_n    = cur_byte[6:3];
                    size_n    = 32'd0;
                    tid_n     = 3'd0;
                    sid_n     = 2'd0;
                    leb_idx_n = 4'd0;
                    state_n   = cur_byte[2] ? S_EXT : S_LEB;
                end
            end
            S_EXT: if (avail) begin
                ptr_n   = ptr_q + 2'd1;
                pop     = (ptr_q == 2'd3);
                tid_n   = cur_byte[7:5];
                sid_n   = cur_byte[4:3];
                state_n = S_LEB;
            end
            S_LEB: if (avail) begin
                ptr_n = ptr_q + 2'd1;
                pop   = (ptr_q == 2'd3);
                if (leb_bad) begin
                    state_n = S_ERR; err_n = 1'b1; code_n = 3'd3;
                end else begin
                    size_n    = size_acc;
                    leb_idx_n = leb_idx_q + 4'd1;
                    if (!cur_byte[7]) begin
                        off_n = ptr_q + 2'd1;
                        if (size_acc == 32'd0) begin
                            cnt_n   = obu_count + 16'd1;
                            state_n = S_HDR;
                        end else begin
                            first_n = 1'b1;
                            state_n = S_DISP;
                            case (obu_type)
                                4'd1:       sel_n = 2'd1;
                                4'd3, 4'd6: sel_n = 2'd2;
                                4'd4:       sel_n = 2'd3;
                                default: begin
                                    first_n = 1'b0;
                                    rem_n   = size_acc;
                                    state_n = S_SKIP;
                                end
                            endcase
                        end
                    end
                end
            end
            S_DISP: begin
                pop         = sub_pop & avail;
                seq_start   = first_q && (sel == 2'd1);
                frame_start = first_q && (sel == 2'd2);
                tile_start  = first_q && (sel == 2'd3);
                // A done in the same cycle as the start pulse is too early to be real.
                if (sub_done && !first_q) begin
                    sel_n = 2'd0;
                    if (sub_bytes_used > obu_size) begin
                        state_n = S_ERR; err_n = 1'b1; code_n = 3'd4;
                    end else begin
                        ptr_n = done_end[1:0];
                        rem_n = done_rem;
                        if (done_rem == 32'd0) begin
                            cnt_n   = obu_count + 16'd1;
                            state_n = S_HDR;
                        end else begin
                            state_n = S_SKIP;
                        end
                    end
                end
            end
            S_SKIP: if (avail) begin
                rem_n = remaining_q - {29'd0, skip_n};
                ptr_n = skip_end[1:0];
                pop   = (skip_end == 3'd4);
                if (remaining_q == {29'd0, skip_n}) begin
                    cnt_n   = obu_count + 16'd1;
                    state_n = S_HDR;
                end
            end
            default: ;
        endcase
    end

    // State and output registers; synchronous reset clears everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            ptr_q          <= 2'd0;
            remaining_q    <= 32'd0;
            leb_idx_q      <= 4'd0;
            first_q        <= 1'b0;
            sel            <= 2'd0;
            obu_type       <= 4'd0;
            obu_size       <= 32'd0;
            payload_offset <= 2'd0;
            temporal_id    <= 3'd0;
            spatial_id     <= 2'd0;
            obu_count      <= 16'd0;
            err            <= 1'b0;
            err_code       <= 3'd0;
        end else begin
            state_q        <= state_n;
            ptr_q          <= ptr_n;
            remaining_q    <= rem_n;
            leb_idx_q      <= leb_idx_n;
            first_q        <= first_n;
            sel            <= sel_n;
            obu_type       <= type_n;
            obu_size       <= size_n;
            payload_offset <= off_n;
            temporal_id    <= tid_n;
            spatial_id     <= sid_n;
            obu_count      <= cnt_n;
            err            <= err_n;
            err_code       <= code_n;
        end
    end

endmodule

// File: tb/tb_obu_dispatch_ctrl.sv
// Bench for obu_dispatch_ctrl: byte-stream FIFO model, sub-parser model,
// and a scoreboard of expected dispatch/completion events built with the stream.
module tb_obu_dispatch_ctrl;

    logic        clk = 1'b0;
    logic        rst, avail, start, sub_done, sub_pop;
    logic [31:0] data, sub_bytes_used;
    logic        pop, seq_start, frame_start, tile_start, err;
    logic [1:0]  sel, payload_offset, spatial_id;
    logic [3:0]  obu_type;
    logic [31:0] obu_size;
    logic [2:0]  temporal_id, err_code;
    logic [15:0] obu_count;

    obu_dispatch_ctrl #(.PARSER_DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .data(data), .avail(avail), .start(start),
        .sub_done(sub_done), .sub_bytes_used(sub_bytes_used), .sub_pop(sub_pop),
        .pop(pop), .sel(sel), .seq_start(seq_start), .frame_start(frame_start),
        .tile_start(tile_start), .obu_type(obu_type), .obu_size(obu_size),
        .payload_offset(payload_offset), .temporal_id(temporal_id),
        .spatial_id(spatial_id), .obu_count(obu_count), .err(err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    typedef struct {int ev; int typ; int size; int off; int tid; int sid; int cnt;} exp_t;
    typedef struct {int words; int used; bit hold;} sub_t;

    exp_t        exq[$];
    sub_t        sq[$];
    logic [7:0]  mem [0:1023];
    int          slen, ecnt, wi, need;
    int          nvec = 0, nmis = 0;
    bit          rand_av, mon_en;
    logic        busy, held;
    logic [15:0] prev_cnt;
    exp_t        me;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // FIFO read pointer advances on every accepted pop.
    always @(posedge clk) begin
        if (rst) wi <= 0;
        else if (pop) wi <= wi + 1;
    end

    // FIFO head and avail presented away from the active edge.
    initial forever begin
        @(negedge clk);
        if (wi < (slen + 3) / 4) begin
            data  = {mem[4*wi], mem[4*wi+1], mem[4*wi+2], mem[4*wi+3]};
            avail = !rand_av || ($urandom_range(0, 3) != 0);
        end else begin
            data  = 32'd0;
            avail = 1'b0;
        end
    end

    // Sub-parser model: pops its words, then pulses done with its byte count.
    assign sub_pop = busy && (need != 0);
    always @(posedge clk) begin
        if (rst) begin
            busy <= 1'b0; held <= 1'b0; need <= 0;
            sub_done <= 1'b0; sub_bytes_used <= 32'd0;
        end else begin
            sub_done <= 1'b0;
            if (!busy) begin
                if ((seq_start || frame_start || tile_start) && sq.size() != 0) begin
                    need           <= sq[0].words;
                    sub_bytes_used <= 32'(sq[0].used);
                    held           <= sq[0].hold;
                    busy           <= 1'b1;
                    sq.delete(0);
                end
            end else if (need != 0) begin
                if (avail) need <= need - 1;
            end else if (!held) begin
                sub_done <= 1'b1;
                busy     <= 1'b0;
            end
        end
    end

    // Scoreboard monitor: dispatch pulses and obu_count steps pop expected events.
    initial forever begin
        @(negedge clk);
        if (rst) prev_cnt = 16'd0;
        else begin
            if (mon_en && (seq_start || frame_start || tile_start)) begin
                if (exq.size() == 0) chk("extra_dispatch", 32'd1, 32'd0);
                else begin
                    me = exq.pop_front();
                    chk("disp_sel", 32'(sel), me.ev);
                    chk("disp_pulse", {29'd0, seq_start, frame_start, tile_start},
                        (me.ev == 1) ? 4 : (me.ev == 2) ? 2 : (me.ev == 3) ? 1 : 0);
                    chk("disp_type", 32'(obu_type), me.typ);
                    chk("disp_size", obu_size, me.size);
                    chk("disp_off", 32'(payload_offset), me.off);
                    chk("disp_tid", 32'(temporal_id), me.tid);
                    chk("disp_sid", 32'(spatial_id), me.sid);
                end
            end
            if (obu_count != prev_cnt) begin
                if (mon_en) begin
                    if (exq.size() == 0) chk("extra_done", 32'(obu_count), 32'(prev_cnt));
                    else begin
                        me = exq.pop_front();
                        chk("done_kind", 32'd0, me.ev);
                        chk("done_cnt", 32'(obu_count), me.cnt);
                        chk("done_type", 32'(obu_type), me.typ);
                    end
                end
                prev_cnt = obu_count;
            end
        end
    end

    task automatic push_b(input logic [7:0] b);
        mem[slen] = b;
        slen++;
    endtask

    task automatic clr_stream();
        for (int i = 0; i < 1024; i++) mem[i] = 8'd0;
        slen = 0; ecnt = 0;
        exq.delete(); sq.delete();
    endtask

    // Append one OBU and its expected events; the sub-parser reports 'used' bytes.
    task automatic add_obu(input logic [7:0] hdr, input logic [7:0] ext, input int size, input int used);
        int sz, off, typ, se;
        logic [7:0] b;
        push_b(hdr);
        if (hdr[2]) push_b(ext);
        sz = size;
        do begin
            b  = {1'b0, 7'(sz)};
            sz = sz >> 7;
            if (sz != 0) b[7] = 1'b1;
            push_b(b);
        end while (sz != 0);
        off = slen % 4;
        typ = int'(hdr[6:3]);
        se  = (typ == 1) ? 1 : (typ == 3 || typ == 6) ? 2 : (typ == 4) ? 3 : 0;
        if (size != 0 && se != 0) begin
            exq.push_back('{ev: se, typ: typ, size: size, off: off,
                            tid: hdr[2] ? int'(ext[7:5]) : 0,
                            sid: hdr[2] ? int'(ext[4:3]) : 0, cnt: 0});
            sq.push_back('{words: (off + used) / 4, used: used, hold: 1'b0});
        end
        for (int i = 0; i < size; i++) push_b(8'($urandom));
        ecnt++;
        exq.push_back('{ev: 0, typ: typ, size: 0, off: 0, tid: 0, sid: 0, cnt: ecnt});
    endtask

    // Padding OBU that leaves the stream word-aligned, so the FIFO drains cleanly.
    task automatic align_pad();
        int s;
        s = (4 - (slen + 2) % 4) % 4;
        if (s == 0) s = 4;
        add_obu(8'h7A, 8'h00, s, 0);
    endtask

    task automatic build_main();
        clr_stream();
        add_obu(8'h12, 8'h00, 0, 0);     // temporal delimiter
        add_obu(8'h0A, 8'h00, 11, 7);    // seq header, 4-byte tail skip
        add_obu(8'h16, 8'hE8, 0, 0);     // zero-size OBU with extension
        add_obu(8'h12, 8'h00, 0, 0);
        add_obu(8'h36, 8'h48, 5, 5);     // frame OBU with extension, exact use
        add_obu(8'h7A, 8'h00, 128, 0);   // padding, two-byte LEB
        add_obu(8'h22, 8'h00, 4, 4);     // tile group
        add_obu(8'h1A, 8'h00, 2, 1);     // frame header, 1-byte tail skip
        add_obu(8'h0A, 8'h00, 129, 129); // long seq header
        align_pad();
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 4000 && exq.size() != 0; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        chk({tag, "_left"}, 32'(exq.size()), 32'd0);
        chk({tag, "_sub_left"}, 32'(sq.size()), 32'd0);
        chk({tag, "_no_err"}, 32'(err), 32'd0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_pop"}, 32'(pop), 0);
        chk({tag, "_sel"}, 32'(sel), 0);
        chk({tag, "_starts"}, {29'd0, seq_start, frame_start, tile_start}, 0);
        chk({tag, "_type"}, 32'(obu_type), 0);
        chk({tag, "_size"}, obu_size, 0);
        chk({tag, "_off"}, 32'(payload_offset), 0);
        chk({tag, "_ids"}, {27'd0, temporal_id, spatial_id}, 0);
        chk({tag, "_cnt"}, 32'(obu_count), 0);
        chk({tag, "_err"}, {28'd0, err, err_code}, 0);
    endtask

    task automatic err_case(input string tag, input int code);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        pulse_start();
        for (int i = 0; i < 200 && !err; i++) @(negedge clk);
        chk({tag, "_err"}, 32'(err), 1);
        chk({tag, "_code"}, 32'(err_code), code);
        chk({tag, "_sel"}, 32'(sel), 0);
        repeat (4) begin
            @(negedge clk);
            chk({tag, "_pop_after"}, 32'(pop), 0);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; rand_av = 1'b0; mon_en = 1'b0;
        clr_stream();
        repeat (3) @(negedge clk);
        chk_zero("reset");

        // Full stream, FIFO always ready.
        build_main();
        mon_en = 1'b1;
        @(negedge clk); rst = 1'b0;
        pulse_start();
        drain("main");

        // Same stream content with random avail stalls.
        rst = 1'b1; mon_en = 1'b0;
        build_main();
        rand_av = 1'b1;
        repeat (2) @(negedge clk);
        mon_en = 1'b1; rst = 1'b0;
        pulse_start();
        drain("stall");
        rand_av = 1'b0; mon_en = 1'b0;

        // Error causes; each one latches and freezes the FIFO.
        rst = 1'b1;
        clr_stream();
        push_b(8'h8A); for (int i = 0; i < 11; i++) push_b(8'h12);
        err_case("forbidden", 1);
        clr_stream();
        push_b(8'h08); for (int i = 0; i < 11; i++) push_b(8'h12);
        err_case("no_size", 2);
        clr_stream();
        push_b(8'h0A); repeat (4) push_b(8'hFF); push_b(8'h1F);
        for (int i = 0; i < 6; i++) push_b(8'h00);
        err_case("leb_ovf", 3);
        clr_stream();
        push_b(8'h0A); push_b(8'h0B);
        for (int i = 0; i < 14; i++) push_b(8'h55);
        sq.push_back('{words: 3, used: 12, hold: 1'b0});
        err_case("overuse", 4);

        // Reset while a tile parser holds the stream.
        clr_stream();
        push_b(8'h22); push_b(8'h08);
        for (int i = 0; i < 10; i++) push_b(8'h33);
        sq.push_back('{words: 0, used: 0, hold: 1'b1});
        repeat (2) @(negedge clk);
        rst = 1'b0;
        pulse_start();
        for (int i = 0; i < 50 && sel != 2'd3; i++) @(negedge clk);
        chk("tile_sel", 32'(sel), 3);
        chk("tile_size", obu_size, 8);
        rst = 1'b1;
        @(negedge clk);
        chk_zero("mid_rst");

        // Without start the controller must stay idle, then parse normally.
        clr_stream();
        add_obu(8'h12, 8'h00, 0, 0);
        add_obu(8'h0A, 8'h00, 11, 7);
        align_pad();
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        chk("idle_cnt", 32'(obu_count), 0);
        chk("idle_sel", 32'(sel), 0);
        mon_en = 1'b1;
        pulse_start();
        drain("restart");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

// File: doc/obu_dispatch_ctrl.md
# obu_dispatch_ctrl

Sequencing controller in front of the OBU header parsers. It consumes the 32-bit bitstream word FIFO, decodes each OBU header (header byte, optional extension byte, LEB128 `obu_size`), then does one of two things with the payload. It hands the payload to the sequence-header, frame-header or tile-info parser through a start/done handshake, or it skips the payload itself. It owns the FIFO `pop` except while a sub-parser holds the stream.

## Interface
- `PARSER_DATA_WIDTH`, 32, FIFO word width. Fixed at 32 (4 byte lanes). First stream byte is in `[31:24]`.
- `clk`  in  1  sole clock.
- `rst`  in  1  reset, synchronous, active-high.
- `data`  in  32  FIFO head word.
- `avail`  in  1  FIFO head word valid.
- `start`  in  1  arms the controller from IDLE. Ignored elsewhere.
- `sub_done`  in  1  active sub-parser finished. One-cycle pulse.
- `sub_bytes_used`  in  32  payload bytes consumed by the sub-parser. Valid with `sub_done`.
- `sub_pop`  in  1  sub-parser FIFO pop request.
- `pop`  out  1  FIFO pop.
- `sel`  out  2  stream owner: 0 = controller, 1 = seq, 2 = frame, 3 = tile.
- `seq_start`, `frame_start`, `tile_start`  out  1 each  one-cycle dispatch pulses.
- `obu_type`  out  4  current OBU type.
- `obu_size`  out  32  current payload size.
- `payload_offset`  out  2  byte lane of the first payload byte.
- `temporal_id`  out  3  from the extension byte; 0 if there is no extension.
- `spatial_id`  out  2  from the extension byte; 0 if there is no extension.
- `obu_count`  out  16  completed OBUs. Wraps.
- `err`  out  1  sticky error.
- `err_code`  out  3  first error cause.

## Operation
- Reset value of every output is 0. State is IDLE and the byte pointer `ptr` is 0.
- **States:** IDLE, HDR, EXT, LEB, DISPATCH, SKIP, ERROR.
- **IDLE:** go to HDR on `start`.
- **Byte consumption (HDR, EXT, LEB):** one byte per cycle, taken from lane `ptr` and only while `avail`=1. `ptr` increments mod 4. `pop`=1 in the same cycle the byte at lane 3 is consumed.
- **HDR:** byte bits are `[7]` forbidden, `[6:3]` type, `[2]` ext, `[1]` has_size, `[0]` reserved (ignored).
  - Forbidden=1 → ERROR, code 1.
  - has_size=0 → ERROR, code 2.
  - Otherwise latch the fields and go to EXT if ext=1, else LEB. Clear `obu_size`, `temporal_id` and `spatial_id`.
- **EXT:** `temporal_id` = byte`[7:5]`, `spatial_id` = byte`[4:3]` → LEB.
- **LEB:** byte *i* (i = 0..7) adds bits `[6:0]` at bit position 7*i. Bits landing at or above bit 31 must be 0, else ERROR, code 3. A byte with `[7]`=0 ends the field.
  - Reaching a 9th byte → ERROR, code 3.
  - At the end of the field, set `payload_offset` = `ptr`.
- **After LEB:**
  - `obu_size`=0 → increment `obu_count`, go to HDR. No dispatch.
  - type 1 → DISPATCH, `sel`=1.
  - type 3 or 6 → DISPATCH, `sel`=2.
  - type 4 → DISPATCH, `sel`=3.
  - Any other type → SKIP with remaining = `obu_size`.
- **DISPATCH:**
  - The matching `*_start` pulse is high for the first DISPATCH cycle only.
  - `pop` = `sub_pop` & `avail`.
  - Sub-parser contract at `sub_done`: it has popped exactly floor((`payload_offset` + `sub_bytes_used`)/4) words.
  - On `sub_done`: `ptr` = (`payload_offset` + `sub_bytes_used`)[1:0] and remaining = `obu_size` − `sub_bytes_used`. If `sub_bytes_used` > `obu_size` → ERROR, code 4.
  - Next state is SKIP, or HDR when remaining = 0 (`obu_count`+1). `sel` returns to 0.
- **SKIP:** per cycle with `avail`, take n = min(remaining, 4 − `ptr`) bytes.
  - remaining −= n and `ptr` += n (mod 4).
  - `pop`=1 when `ptr` + n = 4.
  - remaining reaches 0 → `obu_count`+1, go to HDR.
- **ERROR:** absorbing until `rst`. `pop`=0, `sel`=0, no start pulses. `err`=1 and `err_code` holds.
- **Arithmetic:** `obu_size`, remaining and `sub_bytes_used` are unsigned 32-bit. Lane arithmetic is mod 4.

## Timing
- One cycle per header byte while `avail`=1. With no stalls, the last LEB byte at cycle N gives DISPATCH or SKIP at N+1 and the start pulse at N+1.
- `sub_done` is honoured no earlier than the cycle after the start pulse. A `sub_done` outside DISPATCH is ignored.
- `sub_done` at cycle N → `sel`=0 at N+1.
- Skip throughput is up to 4 bytes per cycle. A 128-byte skip starting at `ptr`=0 takes 32 cycles.
- `avail`=0 stalls all consumption. State and `ptr` hold.
- `pop` is never asserted when `avail`=0.
- `rst` in any state, including mid-DISPATCH, forces the reset values on the next edge. The sub-parser is reset by the same `rst`.

## Test plan
- **Temporal delimiter.** Stream word 0x1200_0A0B: `start`, then bytes 0x12, 0x00 → `obu_type`=2, `obu_size`=0, no start pulse, `obu_count`=1 at cycle 3, `ptr`=2.
- **Sequence header dispatch.** Continue the same word with bytes 0x0A, 0x0B → `sel`=1, `seq_start` pulse, `obu_size`=11, `payload_offset`=0, `pop` on the 0x0B byte. Then `sub_done` with `sub_bytes_used`=7 → SKIP of 4 bytes, `obu_count`=2.
- **Frame OBU with extension.** Bytes 0x36, 0x48, 0x05 → `temporal_id`=2, `spatial_id`=1, `sel`=2, `frame_start`, `payload_offset`=3. `sub_bytes_used`=5 → straight to HDR, `ptr`=0.
- **Padding skip.** Bytes 0x7A, 0x80, 0x01 → `obu_size`=128, 32–33 pops, exact `ptr` continuation, next header parsed correctly. Toggle `avail` randomly; the result must be the same.
- **Errors.**
  - Header 0x8A → `err_code` 1.
  - Header 0x08 → `err_code` 2.
  - LEB bytes 0xFF×4, 0x1F → `err_code` 3.
  - `sub_bytes_used`=12 with `obu_size`=11 → `err_code` 4.
  - In all cases `pop` stays 0 afterwards.
- **Reset mid-operation.** Assert `rst` during DISPATCH (`sel`=3) → all outputs 0 next cycle, state IDLE, and a fresh `start` parses normally.
